// File: rtl/piano_pkg.sv
// Shared constants and types for the piano synthesiser blocks.
package piano_pkg;

  localparam int unsigned NUM_KEYS = 13;
  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned VCOUNT_W = $clog2(NUM_KEYS + 1);

  typedef logic [PERIOD_W-1:0] half_period_t;

endpackage

// File: rtl/tone_osc.sv
// One square-wave voice: counts half-period cycles and toggles phase.
module tone_osc #(
  parameter int unsigned PeriodW = piano_pkg::PERIOD_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PeriodW-1:0] half_period_i,
  output logic               phase_o,
  output logic               en_o
);

  logic [PeriodW-1:0] cnt_d, cnt_q;
  logic               phase_d, phase_q;

  always_comb begin
    cnt_d   = cnt_q + PeriodW'(1);
    phase_d = phase_q;
    if (half_period_i == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q >= half_period_i - PeriodW'(1)) begin
      // >= so a period shrink mid-count toggles at once instead of wrapping.
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;
  assign en_o    = (half_period_i != '0);

endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic square-wave synth: per-key oscillators, voice mixer and
// first-order sigma-delta modulator driving a 1-bit speaker pin.
module poly_tone_synth #(
  parameter int unsigned NUM_KEYS = piano_pkg::NUM_KEYS,
  parameter int unsigned PERIOD_W = piano_pkg::PERIOD_W
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [0:NUM_KEYS-1][PERIOD_W-1:0]   noteFrequency,
  output logic                                spkr,
  output logic [$clog2(NUM_KEYS+1)-1:0]       voice_count
);

  localparam int unsigned VcountW = $clog2(NUM_KEYS + 1);
  // Residue stays below NUM_KEYS and level <= NUM_KEYS, so sums fit below 2*NUM_KEYS.
  localparam int unsigned AccW    = $clog2(2 * NUM_KEYS);

  // reset_n is active-high despite its name.
  logic rst;
  assign rst = reset_n;

  logic [NUM_KEYS-1:0] phase, en;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_voice
    tone_osc #(
      .PeriodW (PERIOD_W)
    ) u_osc (
      .clk_i         (clk),
      .rst_i         (rst),
      .half_period_i (noteFrequency[k]),
      .phase_o       (phase[k]),
      .en_o          (en[k])
    );
  end

  logic [VcountW-1:0] level_d, level_q;
  logic [VcountW-1:0] vcount_d, vcount_q;
  logic [AccW-1:0]    acc_d, acc_q;
  logic [AccW-1:0]    sum;
  logic               spkr_d, spkr_q;

  always_comb begin
    level_d  = '0;
    vcount_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      level_d  = level_d + VcountW'(en[k] & phase[k]);
      vcount_d = vcount_d + VcountW'(en[k]);
    end
  end

  always_comb begin
    sum    = acc_q + AccW'(level_q);
    spkr_d = 1'b0;
    acc_d  = sum;
    if (sum >= AccW'(NUM_KEYS)) begin
      spkr_d = 1'b1;
      acc_d  = sum - AccW'(NUM_KEYS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= '0;
      vcount_q <= '0;
      acc_q    <= '0;
      spkr_q   <= 1'b0;
    end else begin
      level_q  <= level_d;
      vcount_q <= vcount_d;
      acc_q    <= acc_d;
      spkr_q   <= spkr_d;
    end
  end

  assign spkr        = spkr_q;
  assign voice_count = vcount_q;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Directed self-checking bench for poly_tone_synth.
module tb_poly_tone_synth;
  import piano_pkg::*;

  logic                              clk;
  logic                              reset_n;
  logic [0:NUM_KEYS-1][PERIOD_W-1:0] nf;
  logic                              spkr;
  logic [VCOUNT_W-1:0]               voice_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  poly_tone_synth dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .noteFrequency (nf),
    .spkr          (spkr),
    .voice_count   (voice_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    int unsigned hi_a, hi_b, hi_c;
    int unsigned lvl_exp [7];
    half_period_t h;

    nf      = '0;
    reset_n = 1'b1;

    // Reset held with all keys pressed: everything stays at zero.
    for (int k = 0; k < NUM_KEYS; k++) nf[k] = 5;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("rst_spkr", spkr, 0);
      check_eq("rst_vcount", voice_count, 0);
      check_eq("rst_level", dut.level_q, 0);
    end

    // Single voice, H=1: level alternates, spkr high 1 cycle in 26.
    apply_reset();
    nf      = '0;
    nf[0]   = 1;
    reset_n = 1'b0;
    step();
    check_eq("single_vcount", voice_count, 1);
    hi_a = 0;
    hi_b = 0;
    for (int i = 2; i <= 53; i++) begin
      step();
      if (i == 2) check_eq("single_level_e2", dut.level_q, 1);
      if (i == 3) check_eq("single_level_e3", dut.level_q, 0);
      if (i <= 26) hi_a += spkr;
      if (i == 27) check_eq("single_spkr_e27", spkr, 1);
      if (i >= 28) hi_b += spkr;
    end
    check_eq("single_hi_early", hi_a, 0);
    check_eq("single_hi_per26", hi_b, 1);

    // Full chord at H=1000: 1001 low, 1000 high, 1000 low, then high.
    apply_reset();
    h = 1000;
    for (int k = 0; k < NUM_KEYS; k++) nf[k] = h;
    reset_n = 1'b0;
    hi_a = 0;
    hi_b = 0;
    hi_c = 0;
    for (int i = 1; i <= 3002; i++) begin
      step();
      if (i == 1) check_eq("chord_vcount", voice_count, 13);
      if (i <= 1001) hi_a += spkr;
      else if (i <= 2001) hi_b += spkr;
      else if (i <= 3001) hi_c += spkr;
      if (i == 1002) check_eq("chord_spkr_rise", spkr, 1);
      if (i == 2002) check_eq("chord_spkr_fall", spkr, 0);
      if (i == 3002) check_eq("chord_spkr_rise2", spkr, 1);
    end
    check_eq("chord_hi_first", hi_a, 0);
    check_eq("chord_hi_second", hi_b, 1000);
    check_eq("chord_hi_third", hi_c, 0);

    // Period shrink on key 3: 100 -> 20 at cnt=50 toggles on the next edge.
    apply_reset();
    nf      = '0;
    nf[3]   = 100;
    reset_n = 1'b0;
    for (int i = 1; i <= 92; i++) begin
      step();
      if (i == 50) nf[3] = 20;
      if (i == 51) check_eq("shrink_level_e51", dut.level_q, 0);
      if (i == 52) check_eq("shrink_level_e52", dut.level_q, 1);
      if (i == 71) check_eq("shrink_level_e71", dut.level_q, 1);
      if (i == 72) check_eq("shrink_level_e72", dut.level_q, 0);
      if (i == 91) check_eq("shrink_level_e91", dut.level_q, 0);
      if (i == 92) check_eq("shrink_level_e92", dut.level_q, 1);
    end

    // Release of key 5 while its phase is high.
    apply_reset();
    nf      = '0;
    nf[5]   = 8;
    reset_n = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    check_eq("rel_level_before", dut.level_q, 1);
    check_eq("rel_vcount_before", voice_count, 1);
    nf[5] = 0;
    step();
    check_eq("rel_level_after", dut.level_q, 0);
    check_eq("rel_vcount_after", voice_count, 0);
    step();
    check_eq("rel_spkr_quiet", spkr, 0);

    // Mid-operation reset with four voices sounding.
    apply_reset();
    nf      = '0;
    nf[0]   = 3;
    nf[1]   = 4;
    nf[2]   = 5;
    nf[3]   = 6;
    reset_n = 1'b0;
    for (int i = 0; i < 20; i++) step();
    reset_n = 1'b1;
    step();
    check_eq("mid_rst_spkr", spkr, 0);
    check_eq("mid_rst_vcount", voice_count, 0);
    check_eq("mid_rst_level", dut.level_q, 0);
    reset_n = 1'b0;
    step();
    check_eq("mid_post_vcount", voice_count, 4);
    check_eq("mid_post_spkr", spkr, 0);
    lvl_exp = '{0, 0, 0, 0, 1, 2, 3};
    for (int j = 2; j <= 6; j++) begin
      step();
      check_eq($sformatf("mid_level_e%0d", j), dut.level_q, lvl_exp[j]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_tone_synth.md
# poly_tone_synth

Polyphonic square-wave synthesiser for the piano top level. It consumes the per-key half-period array produced by the key stage and generates one square-wave voice per key. It sums the active voices into a level and converts that level to the 1-bit `spkr` pin with a first-order sigma-delta modulator. Multiple pressed keys are audible simultaneously instead of only one winning.

## Interface
- `NUM_KEYS`, default 13: number of voices, one per keyboard key.
- `PERIOD_W`, default 32: width of each half-period word.
- `clk` in, 1: system clock.
- `reset_n` in, 1: reset. It is synchronous and active-high despite the port name.
- `noteFrequency` in, `[0:NUM_KEYS-1][PERIOD_W]`: per-voice half-period in `clk` cycles.
  - 0 means the key is released and the voice is silent.
- `spkr` out, 1: sigma-delta bitstream to the speaker pin.
- `voice_count` out, `$clog2(NUM_KEYS+1)` (4 bits): number of active voices, for LED/debug.

## Operation
- Reset, at the clock edge with `reset_n`=1:
  - Every oscillator's `cnt`=0 and `phase`=0.
  - `level`=0, `acc`=0, `spkr`=0, `voice_count`=0.
- Oscillator k, with `H`=`noteFrequency[k]` sampled every edge:
  - `H`=0: `cnt`<=0, `phase`<=0. The voice is inactive.
  - `H`≠0 and `cnt` ≥ `H`-1: `cnt`<=0, `phase`<=~`phase`.
  - Otherwise: `cnt`<=`cnt`+1.
  - Comparing with ≥ makes a mid-count shrink of `H` toggle on the next edge, never wrapping past 2^32.
  - `H`=1 toggles `phase` every cycle.
- A newly pressed voice starts with `phase`=0 (low) and goes high after `H` cycles.
- Mixer, registered:
  - `level` <= count of voices with `H`≠0 and `phase`=1. Range 0..`NUM_KEYS`.
  - `voice_count` <= count of voices with `H`≠0.
- Modulator, registered:
  - `acc` is 5 bits and satisfies the invariant `acc` < `NUM_KEYS`.
  - `s` = `acc` + `level`, at most 25, so no overflow.
  - `s` ≥ `NUM_KEYS`: `spkr`<=1, `acc`<=`s`-`NUM_KEYS`.
  - Otherwise: `spkr`<=0, `acc`<=`s`.
- Modulator boundary cases:
  - Long-run `spkr` duty equals `level`/`NUM_KEYS`.
  - `level`=`NUM_KEYS` gives constant 1.
  - `level`=0 gives constant 0 once the residue is below `NUM_KEYS`, which always holds.
- A key release (`H`→0) forces that voice's `phase` low on the next edge, regardless of its count.
- Reset asserted mid-operation clears all state at that edge. Outputs are 0 from the following cycle until `reset_n` deasserts. Oscillators restart from `cnt`=0, `phase`=0.

## Timing
- Single clock domain. `noteFrequency` is assumed synchronous to `clk` and stable per cycle.
- Latency from a `phase` change to `level`: 1 cycle.
- Latency from `level` to `spkr`: 1 cycle.
- Latency from an `H` change to `voice_count`: 1 cycle.
- A constant `H` yields a `phase` period of exactly 2·`H` cycles.
- Changing `H` from one nonzero value to another does not reset `cnt` or `phase`. Pitch changes are glitch-free apart from the single shortened half-cycle.
- The mixer adder tree for 13 one-bit inputs must close at the system clock in one cycle. No further pipelining.

## Structure
- `piano_pkg` holds:
  - `NUM_KEYS`, `PERIOD_W`.
  - `VCOUNT_W` = `$clog2(NUM_KEYS+1)`.
  - typedef `half_period_t` = `logic [PERIOD_W-1:0]`.
- Sub-module `tone_osc`:
  - One voice, containing `cnt`, `phase` and the enable output.
  - Instantiated `NUM_KEYS` times in a generate loop.
- Mixer and sigma-delta modulator live in `poly_tone_synth`.

## Test plan
- Reset: drive all `H`=5 while `reset_n`=1 for 10 cycles -> `spkr`=0, `voice_count`=0, every `phase`=0 throughout.
- Single voice: key 0 `H`=1, others 0, `acc`=0 -> `level` alternates 0,1. Over every 26 cycles `spkr` is high exactly 1 cycle. `voice_count`=1.
- Full chord: all 13 keys `H`=1000 applied in the same cycle -> `spkr`=0 for the first ~1000 cycles. It is then 1 continuously for 1000 cycles, then 0 for 1000, repeating. `voice_count`=13.
- Period shrink: key 3 `H`=100; at `cnt`=50 change `H` to 20 -> `phase` toggles on the next edge. Then it toggles every 20 cycles, with no 2^32 wrap.
- Release: key 5 `H`=8 while `phase`=1, then `H`=0 -> `phase`=0 on the next edge. `level` and `voice_count` each drop by 1 one cycle later.
- Mid-operation reset: 4 voices sounding, assert `reset_n` for 1 cycle -> all state is 0 after the edge. On deassertion each voice rises after exactly `H` cycles.
